multiplier: RTL and testbench

Sequential shift-and-add multiplier with AXI-stream handshakes that forms the full-width product of two SIZE-bit unsigned operands. It sits directly upstream of the `modulo` block in the ElGamal datapath. Its 2·SIZE-bit product feeds `input_dividen_tdata`, which together implement one modular multiplication step of the exponentiation.

---
 rtl/multiplier.sv | 143 ++++++++++++++
 tb/tb_multiplier.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/multiplier.sv
// rtl/multiplier.sv - sequential shift-and-add multiplier, full 2*SIZE-bit product, stream handshakes.
// Define MULT_RADIX4_EN to retire two multiplier bits per cycle (halves latency, same results).
module multiplier #(
    parameter int SIZE = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SIZE-1:0]     input_a_tdata,
    input  logic                input_a_tvalid,
    output logic                input_a_tready,
    input  logic [SIZE-1:0]     input_b_tdata,
    input  logic                input_b_tvalid,
    output logic                input_b_tready,
    output logic [2*SIZE-1:0]   output_tdata,
    output logic                output_tvalid,
    input  logic                output_tready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(SIZE);
`ifdef MULT_RADIX4_EN
    localparam int LAST = SIZE / 2 - 1;
`else
    localparam int LAST = SIZE - 1;
`endif

    state_t               state;
    state_t               state_nxt;
    logic                 accept;
    logic                 last_iter;
    logic [2*SIZE-1:0]    mcand;
    logic [SIZE-1:0]      mplier;
    logic [2*SIZE-1:0]    acc;
    logic [CW-1:0]        count;
    logic [2*SIZE-1:0]    addend;
    logic [2*SIZE-1:0]    acc_nxt;
    logic [2*SIZE-1:0]    a_ext;

    assign a_ext     = {{SIZE{1'b0}}, input_a_tdata};
    assign last_iter = (state == RUN) && (count == CW'(LAST));
    assign acc_nxt   = acc + addend;

`ifdef MULT_RADIX4_EN
    logic [2*SIZE-1:0] mcand3;

    always_comb begin
        addend = '0;
        case (mplier[1:0])
            2'd0: addend = '0;
            2'd1: addend = mcand;
            2'd2: addend = mcand << 1;
            2'd3: addend = mcand3;
            default: addend = '0;
        endcase
    end
`else
    always_comb begin
        addend = mplier[0] ? mcand : '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        input_a_tready = 1'b0;
        input_b_tready = 1'b0;
        output_tvalid  = 1'b0;
        accept         = 1'b0;
        case (state)
            IDLE: begin
                input_a_tready = !rst;
                input_b_tready = !rst;
                // Both operands must arrive together; a lone valid is left pending.
                if (input_a_tvalid && input_b_tvalid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                output_tvalid = 1'b1;
                if (output_tready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand        <= '0;
            mplier       <= '0;
            acc          <= '0;
            count        <= '0;
            output_tdata <= '0;
`ifdef MULT_RADIX4_EN
            mcand3       <= '0;
`endif
        end else begin
            if (accept) begin
                mcand  <= a_ext;
                mplier <= input_b_tdata;
                acc    <= '0;
                count  <= '0;
`ifdef MULT_RADIX4_EN
                mcand3 <= a_ext + (a_ext << 1);
`endif
            end
            if (state == RUN) begin
                acc   <= acc_nxt;
                count <= count + CW'(1);
`ifdef MULT_RADIX4_EN
                mcand  <= mcand << 2;
                mplier <= mplier >> 2;
`else
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
`endif
                if (last_iter) begin
                    output_tdata <= acc_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// tb/tb_multiplier.sv - directed self-checking bench for multiplier.
module tb_multiplier;

    localparam int SIZE = 64;
`ifdef MULT_RADIX4_EN
    localparam int LAT = SIZE / 2;
`else
    localparam int LAT = SIZE;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [SIZE-1:0]     input_a_tdata = '0;
    logic                input_a_tvalid = 1'b0;
    logic                input_a_tready;
    logic [SIZE-1:0]     input_b_tdata = '0;
    logic                input_b_tvalid = 1'b0;
    logic                input_b_tready;
    logic [2*SIZE-1:0]   output_tdata;
    logic                output_tvalid;
    logic                output_tready = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multiplier #(.SIZE(SIZE)) dut (
        .clk            (clk),
        .rst            (rst),
        .input_a_tdata  (input_a_tdata),
        .input_a_tvalid (input_a_tvalid),
        .input_a_tready (input_a_tready),
        .input_b_tdata  (input_b_tdata),
        .input_b_tvalid (input_b_tvalid),
        .input_b_tready (input_b_tready),
        .output_tdata   (output_tdata),
        .output_tvalid  (output_tvalid),
        .output_tready  (output_tready)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a pair, then counts cycles from the acceptance edge to output_tvalid.
    task automatic start_and_wait(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                  output int lat);
        input_a_tdata  = a;
        input_b_tdata  = b;
        input_a_tvalid = 1'b1;
        input_b_tvalid = 1'b1;
        step();
        input_a_tvalid = 1'b0;
        input_b_tvalid = 1'b0;
        lat = 0;
        while (!output_tvalid && lat < 4 * SIZE) begin
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                          input logic [127:0] exp);
        int lat;
        start_and_wait(a, b, lat);
        check({tag, "_lat"}, 128'(lat), 128'(LAT));
        check({tag, "_prod"}, output_tdata, exp);
        step();
        check({tag, "_pulse"}, 128'(output_tvalid), 128'(0));
        check({tag, "_rdy"}, 128'({input_a_tready, input_b_tready}), 128'(2'b11));
    endtask

    initial begin
        int lat;
        logic [127:0] held;
        logic seen;

        step();
        check("rst_tready", 128'({input_a_tready, input_b_tready}), 128'(0));
        step();
        check("rst_tvalid", 128'(output_tvalid), 128'(0));
        check("rst_tdata", output_tdata, 128'(0));
        rst = 1'b0;
        step();
        check("idle_tready", 128'({input_a_tready, input_b_tready}), 128'(2'b11));

        run_op("3x5", 64'd3, 64'd5, 128'd15);
        run_op("max", {64{1'b1}}, {64{1'b1}}, 128'hFFFFFFFFFFFFFFFE_0000000000000001);
        run_op("a0", 64'd0, 64'hDEADBEEF, 128'd0);
        run_op("b0", 64'hDEADBEEF, 64'd0, 128'd0);
        run_op("mix", 64'h1_0000_0001, 64'h10, 128'h10_0000_0010);

        // Backpressure: result held, inputs blocked, a new pair ignored.
        output_tready = 1'b0;
        start_and_wait(64'd11, 64'd13, lat);
        check("bp_lat", 128'(lat), 128'(LAT));
        held = output_tdata;
        check("bp_prod", held, 128'd143);
        input_a_tdata  = 64'd1;
        input_b_tdata  = 64'd1;
        input_a_tvalid = 1'b1;
        input_b_tvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold", {output_tvalid, input_a_tready, input_b_tready, output_tdata[124:0]},
                  {3'b100, held[124:0]});
        end
        input_a_tvalid = 1'b0;
        input_b_tvalid = 1'b0;
        output_tready = 1'b1;
        step();
        check("bp_xfer", 128'({output_tvalid, input_a_tready, input_b_tready}), 128'(3'b011));
        seen = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            step();
            if (output_tvalid) seen = 1'b1;
        end
        check("bp_no_extra", 128'(seen), 128'(0));

        // Partial input: lone a never consumed.
        input_a_tdata  = 64'd6;
        input_a_tvalid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!input_a_tready || output_tvalid) seen = 1'b1;
        end
        check("partial_idle", 128'(seen), 128'(0));
        run_op("6x7", 64'd6, 64'd7, 128'd42);

        // Reset 20 cycles into a run: that product must never appear.
        input_a_tdata  = 64'd100;
        input_b_tdata  = 64'd100;
        input_a_tvalid = 1'b1;
        input_b_tvalid = 1'b1;
        step();
        input_a_tvalid = 1'b0;
        input_b_tvalid = 1'b0;
        for (int i = 0; i < 19; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst", {output_tvalid, output_tdata}, 129'(0));
        seen = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            step();
            if (output_tvalid) seen = 1'b1;
        end
        check("mid_rst_quiet", 128'(seen), 128'(0));
        run_op("2x9", 64'd2, 64'd9, 128'd18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
